// File: rtl/cu_command_arbiter.sv
// ---------------------------------------------------------------------------
// cu_command_arbiter
//
// Shares the single CAPI command buffer input among NUM_REQ command sources
// inside a compute unit (read engine, prefetch read, write engine, prefetch
// write). Grants rotate round-robin starting just after the last winner.
// Each source is capped at MAX_OUTSTANDING in-flight commands. Every issued
// command is tagged with its source id, and a credit is returned when a
// response carrying that id comes back.
//
// Ports:
//   clock            single clock, all logic on the rising edge
//   rst_in           asynchronous active-high reset
//   enabled_in       global enable; no grants while low
//   req_valid_in     per-requester command valid
//   req_cmd_in       per-requester payload, slice i at [i*CMD_WIDTH +: CMD_WIDTH]
//   req_ready_out    one-hot grant (a handshake is valid & ready)
//   cmd_alfull_in    command buffer almost-full; blocks every grant
//   cmd_valid_out    registered command valid
//   cmd_out          registered payload of the granted requester
//   cmd_id_out       registered source id that goes with cmd_out
//   rsp_valid_in     one response returned this cycle
//   rsp_id_in        source id of that response
//   outstanding_out  per-requester in-flight count, slice i at [i*8 +: 8]
//   idle_out         no command in flight and no command on the output
//   err_out          sticky protocol error (underflow or unknown id)
// ---------------------------------------------------------------------------
module cu_command_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int CMD_WIDTH       = 128,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ID_WIDTH        = 2
) (
    input  logic                           clock,
    input  logic                           rst_in,
    input  logic                           enabled_in,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]   req_cmd_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    input  logic                           cmd_alfull_in,
    output logic                           cmd_valid_out,
    output logic [CMD_WIDTH-1:0]           cmd_out,
    output logic [ID_WIDTH-1:0]            cmd_id_out,
    input  logic                           rsp_valid_in,
    input  logic [ID_WIDTH-1:0]            rsp_id_in,
    output logic [NUM_REQ*8-1:0]           outstanding_out,
    output logic                           idle_out,
    output logic                           err_out
);

    localparam logic [7:0] CAP = 8'(MAX_OUTSTANDING);

    logic [ID_WIDTH-1:0]  last_grant;
    logic [7:0]           count [NUM_REQ];

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_WIDTH-1:0]  grant_idx;
    logic [CMD_WIDTH-1:0] grant_cmd;
    logic                 grant_found;
    int                   scan_idx;

    logic [NUM_REQ-1:0]   rsp_hit;
    logic [NUM_REQ-1:0]   underflow;
    logic                 rsp_bad_id;

    // Eligibility uses the registered count, so a requester sitting at the
    // cap stays blocked for the cycle in which its credit comes back.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = enabled_in && !cmd_alfull_in && req_valid_in[i]
                          && (count[i] < CAP);
        end
    end

    // Round-robin scan beginning one past the previous winner. The first
    // eligible requester found wins; its payload and index are captured for
    // the output register at the same time.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_cmd   = '0;
        grant_found = 1'b0;
        scan_idx    = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            scan_idx = (int'(last_grant) + off) % NUM_REQ;
            if (!grant_found && eligible[scan_idx]) begin
                grant_found        = 1'b1;
                grant[scan_idx]    = 1'b1;
                grant_idx          = ID_WIDTH'(scan_idx);
                grant_cmd          = req_cmd_in[scan_idx*CMD_WIDTH +: CMD_WIDTH];
            end
        end
    end

    // Ready is forced low while reset is held so no requester believes a
    // handshake completed that the registers cannot record.
    always_comb begin
        req_ready_out = rst_in ? '0 : grant;
    end

    // Response decode. An id beyond the requester range matches no counter
    // and is flagged. A response to an empty counter is an underflow unless
    // a grant to that requester lands in the same cycle, which nets to zero.
    always_comb begin
        rsp_hit    = '0;
        underflow  = '0;
        rsp_bad_id = rsp_valid_in && (int'(rsp_id_in) >= NUM_REQ);
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_hit[i]   = rsp_valid_in && (int'(rsp_id_in) == i);
            underflow[i] = rsp_hit[i] && !grant[i] && (count[i] == 8'd0);
        end
    end

    // Output register and priority pointer. Payload and id hold their last
    // values when nothing is granted; only the valid bit drops.
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            last_grant    <= ID_WIDTH'(NUM_REQ - 1);
            cmd_valid_out <= 1'b0;
            cmd_out       <= '0;
            cmd_id_out    <= '0;
        end else begin
            cmd_valid_out <= grant_found;
            if (grant_found) begin
                cmd_out    <= grant_cmd;
                cmd_id_out <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

    // Per-requester in-flight counters. The increment cannot overflow since
    // a grant only happens below the cap, and the decrement saturates at 0.
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                count[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && !rsp_hit[i]) begin
                    count[i] <= count[i] + 8'd1;
                end else if (!grant[i] && rsp_hit[i] && (count[i] != 8'd0)) begin
                    count[i] <= count[i] - 8'd1;
                end
            end
        end
    end

    // Sticky error: once set, only reset clears it.
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            err_out <= 1'b0;
        end else if (rsp_bad_id || (|underflow)) begin
            err_out <= 1'b1;
        end
    end

    // Flatten the counters and derive idle from registered state only.
    always_comb begin
        outstanding_out = '0;
        idle_out        = !cmd_valid_out;
        for (int i = 0; i < NUM_REQ; i++) begin
            outstanding_out[i*8 +: 8] = count[i];
            if (count[i] != 8'd0) begin
                idle_out = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cu_command_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cu_command_arbiter
//
// Self-checking bench for cu_command_arbiter with NUM_REQ=4,
// MAX_OUTSTANDING=2 and ID_WIDTH=3 (so id 4 is an out-of-range response).
// A table of per-cycle vectors holds the inputs together with the expected
// grant, the counters and the error flag before the clock edge. Expected
// commands are queued when a grant is expected and popped when the output
// register is checked one cycle later. Reset behaviour is driven by hand.
// ---------------------------------------------------------------------------
module tb_cu_command_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int CMD_WIDTH = 16;
    localparam int MAX_OUT   = 2;
    localparam int ID_WIDTH  = 3;

    logic                         clock = 1'b0;
    logic                         rst_in;
    logic                         enabled_in;
    logic [NUM_REQ-1:0]           req_valid_in;
    logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd_in;
    logic [NUM_REQ-1:0]           req_ready_out;
    logic                         cmd_alfull_in;
    logic                         cmd_valid_out;
    logic [CMD_WIDTH-1:0]         cmd_out;
    logic [ID_WIDTH-1:0]          cmd_id_out;
    logic                         rsp_valid_in;
    logic [ID_WIDTH-1:0]          rsp_id_in;
    logic [NUM_REQ*8-1:0]         outstanding_out;
    logic                         idle_out;
    logic                         err_out;

    always #5 clock = ~clock;

    cu_command_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .CMD_WIDTH       (CMD_WIDTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .ID_WIDTH        (ID_WIDTH)
    ) dut (
        .clock           (clock),
        .rst_in          (rst_in),
        .enabled_in      (enabled_in),
        .req_valid_in    (req_valid_in),
        .req_cmd_in      (req_cmd_in),
        .req_ready_out   (req_ready_out),
        .cmd_alfull_in   (cmd_alfull_in),
        .cmd_valid_out   (cmd_valid_out),
        .cmd_out         (cmd_out),
        .cmd_id_out      (cmd_id_out),
        .rsp_valid_in    (rsp_valid_in),
        .rsp_id_in       (rsp_id_in),
        .outstanding_out (outstanding_out),
        .idle_out        (idle_out),
        .err_out         (err_out)
    );

    typedef struct {
        logic        en;
        logic        alfull;
        logic [3:0]  valid;
        logic        rspv;
        logic [2:0]  rspid;
        logic [3:0]  exp_ready;
        logic [31:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [ID_WIDTH-1:0]  id;
        logic [CMD_WIDTH-1:0] cmd;
    } exp_cmd_t;

    vec_t                 vecs[$];
    exp_cmd_t             sb[$];
    int                   total = 0;
    int                   bad   = 0;
    int                   step_no = 0;
    logic                 prev_grant = 1'b0;
    logic [CMD_WIDTH-1:0] last_cmd = '0;
    logic [ID_WIDTH-1:0]  last_id  = '0;

    function automatic vec_t mk(logic en, logic alfull, logic [3:0] valid,
                                logic rspv, logic [2:0] rspid, logic [3:0] exp_ready,
                                int c0, int c1, int c2, int c3, logic exp_err);
        vec_t v;
        v.en        = en;
        v.alfull    = alfull;
        v.valid     = valid;
        v.rspv      = rspv;
        v.rspid     = rspid;
        v.exp_ready = exp_ready;
        v.exp_cnt   = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
        v.exp_err   = exp_err;
        return v;
    endfunction

    function automatic logic [CMD_WIDTH-1:0] payload(int step, int i);
        return {8'(step), 4'(i), 4'hC};
    endfunction

    // One comparison; every mismatch prints a single FAIL line.
    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s step=%0d: got %0h want %0h", name, step_no, act, req);
        end
    endtask

    // Drive one vector at the falling edge, check the combinational grant and
    // pre-edge state, then check the output register after the rising edge.
    task automatic apply_stimulus(input vec_t v);
        int gidx;
        exp_cmd_t e;
        @(negedge clock);
        enabled_in    = v.en;
        cmd_alfull_in = v.alfull;
        req_valid_in  = v.valid;
        rsp_valid_in  = v.rspv;
        rsp_id_in     = v.rspid;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_cmd_in[i*CMD_WIDTH +: CMD_WIDTH] = payload(step_no, i);
        end
        #1;
        check_output("ready", 32'(req_ready_out), 32'(v.exp_ready));
        check_output("outstanding", outstanding_out, v.exp_cnt);
        check_output("err", 32'(err_out), 32'(v.exp_err));
        check_output("idle", 32'(idle_out), 32'((v.exp_cnt == 32'd0) && !prev_grant));
        gidx = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v.exp_ready[i]) gidx = i;
        end
        if (gidx >= 0) begin
            e.id  = ID_WIDTH'(gidx);
            e.cmd = payload(step_no, gidx);
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        check_output("cmd_valid", 32'(cmd_valid_out), 32'(gidx >= 0));
        if (gidx >= 0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL scoreboard step=%0d: got empty queue want entry", step_no);
            end else begin
                e = sb.pop_front();
                check_output("cmd_id", 32'(cmd_id_out), 32'(e.id));
                check_output("cmd", 32'(cmd_out), 32'(e.cmd));
                last_id  = e.id;
                last_cmd = e.cmd;
            end
        end else begin
            check_output("cmd_hold", 32'(cmd_out), 32'(last_cmd));
            check_output("id_hold", 32'(cmd_id_out), 32'(last_id));
        end
        prev_grant = (gidx >= 0);
        step_no++;
    endtask

    initial begin
        // Reset state, with every requester asserting valid to prove ready
        // stays low while reset is held.
        rst_in        = 1'b1;
        enabled_in    = 1'b1;
        cmd_alfull_in = 1'b0;
        req_valid_in  = 4'b1111;
        req_cmd_in    = '0;
        rsp_valid_in  = 1'b0;
        rsp_id_in     = '0;
        #2;
        check_output("rst_ready", 32'(req_ready_out), 32'd0);
        check_output("rst_idle", 32'(idle_out), 32'd1);
        check_output("rst_valid", 32'(cmd_valid_out), 32'd0);
        check_output("rst_cnt", outstanding_out, 32'd0);
        check_output("rst_err", 32'(err_out), 32'd0);
        @(negedge clock);
        req_valid_in = 4'b0000;
        rst_in       = 1'b0;

        // All valid with responses every cycle: rotation 0,1,2,3,0,1.
        vecs.push_back(mk(1,0,4'b1111,0,0,4'b0001, 0,0,0,0, 0));
        vecs.push_back(mk(1,0,4'b1111,1,0,4'b0010, 1,0,0,0, 0));
        vecs.push_back(mk(1,0,4'b1111,1,1,4'b0100, 0,1,0,0, 0));
        vecs.push_back(mk(1,0,4'b1111,1,2,4'b1000, 0,0,1,0, 0));
        vecs.push_back(mk(1,0,4'b1111,1,3,4'b0001, 0,0,0,1, 0));
        vecs.push_back(mk(1,0,4'b1111,1,0,4'b0010, 1,0,0,0, 0));
        vecs.push_back(mk(1,0,4'b0000,1,1,4'b0000, 0,1,0,0, 0));
        // Requester 2 alone hits the cap; a returned credit unblocks it a
        // cycle later.
        vecs.push_back(mk(1,0,4'b0100,0,0,4'b0100, 0,0,0,0, 0));
        vecs.push_back(mk(1,0,4'b0100,0,0,4'b0100, 0,0,1,0, 0));
        vecs.push_back(mk(1,0,4'b0100,0,0,4'b0000, 0,0,2,0, 0));
        vecs.push_back(mk(1,0,4'b0100,1,2,4'b0000, 0,0,2,0, 0));
        vecs.push_back(mk(1,0,4'b0100,0,0,4'b0100, 0,0,1,0, 0));
        vecs.push_back(mk(1,0,4'b0000,1,2,4'b0000, 0,0,2,0, 0));
        vecs.push_back(mk(1,0,4'b0000,1,2,4'b0000, 0,0,1,0, 0));
        // Almost-full for five cycles, then rotation resumes after 2.
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(1,1,4'b1111,0,0,4'b0000, 0,0,0,0, 0));
        end
        vecs.push_back(mk(1,0,4'b1111,0,0,4'b1000, 0,0,0,0, 0));
        vecs.push_back(mk(1,0,4'b0000,1,3,4'b0000, 0,0,0,1, 0));
        vecs.push_back(mk(0,0,4'b1111,0,0,4'b0000, 0,0,0,0, 0));
        // Grant and response to requester 1 in the same cycle.
        vecs.push_back(mk(1,0,4'b0010,0,0,4'b0010, 0,0,0,0, 0));
        vecs.push_back(mk(1,0,4'b0010,1,1,4'b0010, 0,1,0,0, 0));
        vecs.push_back(mk(1,0,4'b0000,0,0,4'b0000, 0,1,0,0, 0));
        vecs.push_back(mk(1,0,4'b0000,1,1,4'b0000, 0,1,0,0, 0));
        // Underflow on id 3, then out-of-range id 4 with counter 0 busy.
        vecs.push_back(mk(1,0,4'b0001,1,3,4'b0001, 0,0,0,0, 0));
        vecs.push_back(mk(1,0,4'b0000,1,4,4'b0000, 1,0,0,0, 1));
        vecs.push_back(mk(1,0,4'b0000,0,0,4'b0000, 1,0,0,0, 1));
        // Build counts 2,1,0,2 and confirm both capped requesters block.
        vecs.push_back(mk(1,0,4'b1011,0,0,4'b0010, 1,0,0,0, 1));
        vecs.push_back(mk(1,0,4'b1001,0,0,4'b1000, 1,1,0,0, 1));
        vecs.push_back(mk(1,0,4'b1001,0,0,4'b0001, 1,1,0,1, 1));
        vecs.push_back(mk(1,0,4'b1001,0,0,4'b1000, 2,1,0,1, 1));
        vecs.push_back(mk(1,0,4'b1001,0,0,4'b0000, 2,1,0,2, 1));

        for (int n = 0; n < vecs.size(); n++) begin
            apply_stimulus(vecs[n]);
        end

        // Reset pulsed mid-cycle with counters at 2,1,0,2: everything clears
        // without waiting for a clock edge.
        @(negedge clock);
        req_valid_in = 4'b1111;
        rsp_valid_in = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        check_output("mid_rst_valid", 32'(cmd_valid_out), 32'd0);
        check_output("mid_rst_cmd", 32'(cmd_out), 32'd0);
        check_output("mid_rst_id", 32'(cmd_id_out), 32'd0);
        check_output("mid_rst_cnt", outstanding_out, 32'd0);
        check_output("mid_rst_err", 32'(err_out), 32'd0);
        check_output("mid_rst_idle", 32'(idle_out), 32'd1);
        check_output("mid_rst_ready", 32'(req_ready_out), 32'd0);
        prev_grant = 1'b0;
        last_cmd   = '0;
        last_id    = '0;
        @(negedge clock);
        req_valid_in = 4'b0000;
        rst_in       = 1'b0;

        // First grant after reset goes to requester 0; a late response is
        // then seen as an underflow.
        apply_stimulus(mk(1,0,4'b1111,0,0,4'b0001, 0,0,0,0, 0));
        apply_stimulus(mk(1,0,4'b0000,1,1,4'b0000, 1,0,0,0, 0));
        apply_stimulus(mk(1,0,4'b0000,0,0,4'b0000, 1,0,0,0, 1));

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cu_command_arbiter.md
Name: cu_command_arbiter

Overview:
Round-robin arbiter that shares one CAPI command buffer input among NUM_REQ command sources inside a compute unit (read engine, prefetch read, write engine, prefetch write). It enforces a per-source cap on outstanding commands, tags each issued command with its source id, and returns credits when tagged responses arrive. Its output register drives the command buffer directly, so it sits between the engine controls and the command buffer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CMD_WIDTH, 128, command payload bits per requester
MAX_OUTSTANDING, 8, max in-flight commands per requester (1..255)
ID_WIDTH, 2, source id bits; must be at least $clog2(NUM_REQ), minimum 1

Ports:
clock  in  1  single clock, all logic posedge
rst_in  in  1  asynchronous, active-high reset
enabled_in  in  1  global enable; when low, no grants are made
req_valid_in  in  NUM_REQ  bit i: requester i presents a command
req_cmd_in  in  NUM_REQ*CMD_WIDTH  payload; requester i uses slice [i*CMD_WIDTH +: CMD_WIDTH]
req_ready_out  out  NUM_REQ  one-hot grant; handshake completes when valid and ready are both high
cmd_alfull_in  in  1  command buffer almost-full; blocks all grants
cmd_valid_out  out  1  registered command valid
cmd_out  out  CMD_WIDTH  registered granted payload
cmd_id_out  out  ID_WIDTH  registered source id of cmd_out
rsp_valid_in  in  1  response returned for one command
rsp_id_in  in  ID_WIDTH  source id of the response
outstanding_out  out  NUM_REQ*8  per-requester in-flight count; slice i at [i*8 +: 8]
idle_out  out  1  all counts are zero and cmd_valid_out is low
err_out  out  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous on rst_in high) clears all of the following: cmd_valid_out, cmd_out, cmd_id_out, every outstanding counter, err_out. Priority pointer last_grant resets to NUM_REQ-1, so requester 0 has first priority. idle_out is 1 during reset. req_ready_out is 0 during reset.
- Eligibility: requester i is eligible when all of these hold:
  - enabled_in is high
  - cmd_alfull_in is low
  - req_valid_in[i] is high
  - outstanding[i] < MAX_OUTSTANDING
- Grant (combinational, at most one per cycle): the first eligible requester scanning last_grant+1, last_grant+2, ... modulo NUM_REQ. req_ready_out is the one-hot grant and is zero when nothing is eligible. Ready may depend on valid; requesters must not make valid depend on ready.
- On a grant: last_grant takes the granted index on the next edge. last_grant is unchanged when there is no grant.
- Output register, latency 1 cycle from the handshake:
  - cmd_valid_out <= |grant
  - cmd_out <= payload of the granted requester
  - cmd_id_out <= granted index
  - With no grant: cmd_valid_out <= 0, and cmd_out/cmd_id_out hold their previous values.
- Counter update per requester i, each cycle:
  - increment = grant[i]
  - decrement = rsp_valid_in && rsp_id_in == i
  - both in the same cycle: no change
  - increment only: +1; decrement only: -1
- Boundary, counter at zero: a decrement at outstanding[i]==0 leaves the count at 0 and sets err_out.
- Boundary, bad id: rsp_valid_in with rsp_id_in >= NUM_REQ changes no counter and sets err_out.
- Boundary, counter at cap: a counter at MAX_OUTSTANDING blocks grants to that requester. A response in the same cycle does not unblock it until the next cycle, because eligibility uses the registered count.
- Blocking signals: with enabled_in low or cmd_alfull_in high, no grants are made. Responses and counter decrements continue; last_grant holds.
- err_out stays set until reset.
- idle_out is combinational from the registered counters and cmd_valid_out.
- Reset asserted mid-operation: in-flight counts are discarded with no error. Any response arriving after reset is treated as an underflow and sets err_out; the integrator must drain responses before reset.

Test Plan:
Setup for all scenarios: NUM_REQ=4, MAX_OUTSTANDING=2, enabled_in=1 unless stated otherwise.
1. Reset release, then req_valid_in=4'b1111 held with responses returned every cycle -> grants in order 0,1,2,3,0,... one per cycle. cmd_id_out shows the same sequence one cycle later with the matching payloads.
2. Only requester 2 valid, no responses -> granted on two consecutive cycles, outstanding[2]=2, then req_ready_out=0. A response with rsp_id_in=2 -> granted again on the following cycle.
3. cmd_alfull_in=1 for 5 cycles with all requesters valid -> req_ready_out=0 and cmd_valid_out=0 throughout, last_grant unchanged. On deassertion, the grant resumes at the next requester in rotation.
4. Grant to requester 1 in the same cycle as a response with rsp_id_in=1 while outstanding[1]=1 -> outstanding[1] stays 1 and err_out stays 0.
5. Response with rsp_id_in=3 while outstanding[3]=0, and separately with rsp_id_in=4 on an ID_WIDTH=3 build -> counters unchanged, err_out=1 and sticky until rst_in.
6. rst_in pulsed mid-stream with counters at 2,1,0,2 -> all outputs go to zero asynchronously and idle_out=1. After release, the first grant goes to requester 0.
